// File: rtl/logleft_seq_pkg.sv
// Shared types and sizing helpers for the sequential logical-left shifter.
package logleft_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } lls_state_t;

    // Shift-amount width able to encode 0..n+1.
    function automatic int unsigned amt_w(input int unsigned n);
        return $clog2(n + 2);
    endfunction

    // Largest meaningful shift for an (n+1)-bit word; larger amounts clamp here.
    function automatic int unsigned sat_lim(input int unsigned n);
        return n + 1;
    endfunction

    localparam int unsigned LLS_N_DEF       = 7;
    localparam int unsigned LLS_SAT_LIM_DEF = sat_lim(LLS_N_DEF);

endpackage

// File: rtl/logleft_seq_if.sv
// Job/result handshake bundle for logleft_seq; master drives jobs, slave is the shifter.
interface logleft_seq_if
    import logleft_pkg::*;
#(
    parameter int unsigned N = LLS_N_DEF
);
    localparam int unsigned AW = amt_w(N);

    logic          in_valid;
    logic          in_ready;
    logic [N:0]    a;
    logic [AW-1:0] amt;
    logic          out_valid;
    logic          out_ready;
    logic [N:0]    b;
    logic          carry_out;
    logic          busy;

    modport master (
        output in_valid, a, amt, out_ready,
        input  in_ready, out_valid, b, carry_out, busy
    );

    modport slave (
        input  in_valid, a, amt, out_ready,
        output in_ready, out_valid, b, carry_out, busy
    );

endinterface

// File: rtl/logleft_seq.sv
// Sequential logical-left shifter: one bit per clock, zero fill, last bit out on carry_out.
module logleft_seq
    import logleft_pkg::*;
#(
    parameter int unsigned N = LLS_N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    logleft_seq_if.slave bus
);

    localparam int unsigned W       = N + 1;
    localparam int unsigned AW      = amt_w(N);
    localparam int unsigned SAT_LIM = sat_lim(N);

    lls_state_t    state_q, state_d;
    logic [W-1:0]  b_q, b_d;
    logic          co_q, co_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic [AW-1:0] amt_sat;

    // Clamp oversized shift requests to a full-width shift.
    always_comb begin
        amt_sat = bus.amt;
        if (32'(bus.amt) > SAT_LIM) begin
            amt_sat = AW'(SAT_LIM);
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        co_d    = co_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    b_d     = bus.a;
                    co_d    = 1'b0;
                    cnt_d   = amt_sat;
                    state_d = (amt_sat != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                b_d   = {b_q[W-2:0], 1'b0};
                co_d  = b_q[W-1];
                cnt_d = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            b_q         <= '0;
            co_q        <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            co_q        <= co_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.b         = b_q;
    assign bus.carry_out = co_q;
    assign bus.busy      = busy_q;

endmodule
